uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the Uart8 receiver.
- Captures each completed byte (rxDone) together with its framing-error flag (rxErr) into a FIFO.
- Presents the stored entries on a first-word-fall-through valid/ready interface.
- Throttles the receiver through rxEn using high/low watermarks, changing rxEn only between frames so a frame in progress is never cut off.

Parameters:
- DEPTH, 16: entries; power of two, >= 4.
- HIGH_WATER, 12: fill level at or above which rxEn is dropped; LOW_WATER < HIGH_WATER <= DEPTH.
- LOW_WATER, 4: fill level at or below which rxEn is restored.
- DROP_ERR, 0: 1 = discard bytes flagged rxErr instead of storing them.

Ports:
- clk  in  1  system clock (CLOCK_RATE domain of Uart8).
- rstN  in  1  asynchronous active-low reset.
- rxBusy  in  1  from Uart8; frame in progress.
- rxDone  in  1  from Uart8; byte complete (level or pulse).
- rxErr  in  1  from Uart8; framing error for the current byte; valid while rxDone is high.
- rxByte  in  8  from Uart8 out.
- rxEn  out  1  to Uart8 rxEn.
- outData  out  8  head entry data.
- outErr  out  1  head entry framing-error flag.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts the head entry.
- count  out  $clog2(DEPTH)+1  current fill level.
- overflow  out  1  sticky; a byte was lost because the FIFO was full.
- ovfClr  in  1  synchronous clear of overflow.
- errCount  out  8  saturating count of bytes with rxErr (stored or dropped).

Behaviour:
- Reset (async, rstN=0):
  - wrPtr = rdPtr = count = 0; outValid = 0; overflow = 0; errCount = 0; rxEn = 1.
  - rxDone edge detector register is cleared.
  - outData/outErr are don't-care while outValid = 0.
  - Reset mid-frame: buffer contents are discarded; the receiver is re-enabled immediately.
- Capture:
  - A push event is the rising edge of rxDone: a registered rxDone_q; push when rxDone & ~rxDone_q.
  - Exactly one push per byte, whether rxDone is a 1-cycle pulse or held high.
  - rxByte and rxErr are sampled in the same cycle as the edge.
- DROP_ERR=1 and rxErr=1: no store; errCount still increments.
- Any rxErr=1 at a push event: errCount += 1, saturating at 255.
- Pop: outValid & outReady; rdPtr advances at the next clk edge.
- Output timing:
  - FWFT: outData/outErr reflect mem[rdPtr] combinationally from the registered pointer.
  - A byte pushed at edge N is visible with outValid=1 after edge N; push-to-valid latency is 1 cycle from the rxDone rising edge.
- Full (count==DEPTH):
  - Push with simultaneous pop: both happen, count unchanged.
  - Push without pop: byte dropped, overflow <= 1, count unchanged.
- Empty (count==0): outValid=0; outReady is ignored; a simultaneous push with outReady=1 does not pop (the byte appears next cycle).
- Push and pop on the same cycle in the non-full case: count unchanged; both pointers advance.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count is tracked separately for full/empty.
- Overflow clear: ovfClr=1 clears overflow; if an overflow event occurs in the same cycle, set wins.
- Flow-control FSM (states RUN, DRAIN):
  - RUN: rxEn=1. Go to DRAIN when count >= HIGH_WATER and rxBusy=0. If rxBusy=1, stay in RUN until the frame ends.
  - DRAIN: rxEn=0. Go to RUN when count <= LOW_WATER.
  - rxEn is registered and equals (state==RUN).
  - A byte completing while in DRAIN (rxDone edge) is still captured.
- count update: count_next = count + push_accepted - pop. Width holds DEPTH exactly; no wrap.

Decomposition:
- Shared include (uart_defs.vh):
  - UART_DATA_W = 8.
  - Flow-FSM state encodings FC_RUN = 1'b0, FC_DRAIN = 1'b1.
  - ERRCNT_W = 8.
- One sub-module: uart_fifo_mem, a DEPTH x 9 storage array with synchronous write and asynchronous read ({err, data}).
- Pointer, count, flow and error logic stay in uart_rx_fifo.

Test Plan:
- Single byte: rxByte=8'hB5, 1-cycle rxDone, rxErr=0 -> outValid=1 the next cycle, outData=8'hB5, outErr=0, count=1; outReady pulse -> count=0, outValid=0.
- Held rxDone for 50 cycles with rxByte=8'h3C -> exactly one entry, count=1.
- Error tagging: push 8'hA5 with rxErr=1 at DROP_ERR=0 -> outErr=1, errCount=1. Same stimulus at DROP_ERR=1 -> count=0, errCount=1.
- Watermarks: push 12 bytes with outReady=0 -> rxEn=0 one cycle after the 12th push.
  - Repeat with rxBusy held 1 at the 12th push -> rxEn stays 1 until rxBusy falls.
  - Pop down to 4 entries -> rxEn=1.
- Overflow: push 17 bytes 8'h00..8'h10 with no pops -> count=16, overflow=1, reads yield 8'h00..8'h0F.
  - Push+pop on the same cycle while full -> count stays 16, overflow unchanged.
  - ovfClr -> overflow=0.
- Async reset: assert rstN=0 while count=5, rxEn=0, mid-cycle -> count=0, outValid=0, rxEn=1, errCount=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer.
// Contents: data/counter widths and the flow-control state encoding.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned ERRCNT_W    = 8;

  typedef enum logic {
    FC_RUN   = 1'b0,
    FC_DRAIN = 1'b1
  } fc_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: DEPTH entries of WIDTH bits.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data ({err, data})
//   raddr - read address (asynchronous read)
//   rdata - read data
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents are only observable once pushed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer downstream of the Uart8 receiver.
// Captures each completed byte and its framing-error flag on the rising edge of rxDone,
// presents entries on a first-word-fall-through valid/ready interface and throttles the
// receiver via rxEn using high/low watermarks (changed only between frames).
// Ports:
//   clk, rstN           - clock, asynchronous active-low reset
//   rxBusy/rxDone/rxErr - receiver status; rxByte - received byte
//   rxEn                - receiver enable (registered)
//   outData/outErr      - head entry; outValid - FIFO non-empty; outReady - consumer accept
//   count               - fill level
//   overflow / ovfClr   - sticky lost-byte flag and its synchronous clear
//   errCount            - saturating count of bytes flagged rxErr
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HIGH_WATER = 12,
  parameter int unsigned LOW_WATER  = 4,
  parameter bit          DROP_ERR   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     rxBusy,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [UART_DATA_W-1:0]   rxByte,
  output logic                     rxEn,
  output logic [UART_DATA_W-1:0]   outData,
  output logic                     outErr,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovfClr,
  output logic [ERRCNT_W-1:0]      errCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0]     PtrOne   = PtrW'(1);
  localparam logic [CntW-1:0]     CntOne   = CntW'(1);
  localparam logic [CntW-1:0]     FullLvl  = CntW'(DEPTH);
  localparam logic [CntW-1:0]     HighLvl  = CntW'(HIGH_WATER);
  localparam logic [CntW-1:0]     LowLvl   = CntW'(LOW_WATER);
  localparam logic [ERRCNT_W-1:0] ErrMax   = '1;
  localparam logic [ERRCNT_W-1:0] ErrOne   = ERRCNT_W'(1);

  logic                 rx_done_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q;
  logic [ERRCNT_W-1:0]  err_count_q;
  fc_state_e            fc_q;
  logic                 rx_en_q;

  logic                 push, pop, full, store_req, push_acc, ovf_event;
  logic [UART_DATA_W:0] rd_word;

  // One push per byte regardless of whether rxDone is a pulse or a held level.
  assign push      = rxDone & ~rx_done_q;
  assign full      = (count_q == FullLvl);
  assign outValid  = (count_q != '0);
  assign pop       = outValid & outReady;
  assign store_req = push & ~(DROP_ERR & rxErr);
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_acc  = store_req & (~full | pop);
  assign ovf_event = store_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push_acc && pop) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_done_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      rx_done_q <= rxDone;
      count_q   <= count_d;
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      // Set wins over a same-cycle clear.
      if (ovf_event) begin
        overflow_q <= 1'b1;
      end else if (ovfClr) begin
        overflow_q <= 1'b0;
      end
      if (push && rxErr && (err_count_q != ErrMax)) begin
        err_count_q <= err_count_q + ErrOne;
      end
    end
  end

  // Flow control: only drop rxEn between frames so an in-flight byte is never truncated.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fc_q    <= FC_RUN;
      rx_en_q <= 1'b1;
    end else begin
      unique case (fc_q)
        FC_RUN: begin
          if ((count_q >= HighLvl) && !rxBusy) begin
            fc_q    <= FC_DRAIN;
            rx_en_q <= 1'b0;
          end
        end
        FC_DRAIN: begin
          if (count_q <= LowLvl) begin
            fc_q    <= FC_RUN;
            rx_en_q <= 1'b1;
          end
        end
      endcase
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W + 1)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata ({rxErr, rxByte}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign outData  = rd_word[UART_DATA_W-1:0];
  assign outErr   = rd_word[UART_DATA_W];
  assign rxEn     = rx_en_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign errCount = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo; instance 0 stores errored bytes,
// instance 1 drops them. Both are compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HW    = 12;
  localparam int unsigned LW    = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          rxBusy = 1'b0, rxDone = 1'b0, rxErr = 1'b0;
  logic [7:0]    rxByte = 8'h00;
  logic          outReady = 1'b0, ovfClr = 1'b0;

  logic          rx_en0, rx_en1, out_err0, out_err1, out_valid0, out_valid1, ovf0, ovf1;
  logic [7:0]    out_data0, out_data1, err_cnt0, err_cnt1;
  logic [CW-1:0] count0, count1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .HIGH_WATER(HW), .LOW_WATER(LW), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rstN(rstN), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .rxEn(rx_en0), .outData(out_data0), .outErr(out_err0), .outValid(out_valid0),
    .outReady(outReady), .count(count0), .overflow(ovf0), .ovfClr(ovfClr), .errCount(err_cnt0)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .HIGH_WATER(HW), .LOW_WATER(LW), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rstN(rstN), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .rxEn(rx_en1), .outData(out_data1), .outErr(out_err1), .outValid(out_valid1),
    .outReady(outReady), .count(count1), .overflow(ovf1), .ovfClr(ovfClr), .errCount(err_cnt1)
  );

  // Reference model: one queue of {err, data} per instance.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         m_ovf[2];
  int         m_err[2];
  bit         m_run[2];
  bit         m_prev_done;

  function automatic int msize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] mhead(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic mpop(int i);
    if (i == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic mpush(int i, logic [8:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_prev_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = 1'b0;
      m_err[i] = 0;
      m_run[i] = 1'b1;
    end
  endtask

  task automatic model_inst(int i, bit drop, bit push);
    int sz = msize(i);
    bit pop = (sz > 0) && outReady;
    bit store = push && !(drop && rxErr);
    bit ovf_ev = 1'b0;
    if (pop) mpop(i);
    if (store) begin
      if (sz == DEPTH && !pop) ovf_ev = 1'b1;
      else mpush(i, {rxErr, rxByte});
    end
    if (ovf_ev) m_ovf[i] = 1'b1;
    else if (ovfClr) m_ovf[i] = 1'b0;
    if (push && rxErr && m_err[i] < 255) m_err[i]++;
    if (m_run[i]) begin
      if (sz >= HW && !rxBusy) m_run[i] = 1'b0;
    end else if (sz <= LW) begin
      m_run[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit push;
    if (!rstN) begin
      model_reset();
    end else begin
      push = rxDone && !m_prev_done;
      model_inst(0, 1'b0, push);
      model_inst(1, 1'b1, push);
      m_prev_done = rxDone;
    end
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_inst(int i, logic en, logic [7:0] d, logic e, logic v,
                              logic [CW-1:0] c, logic o, logic [7:0] ec);
    logic [8:0] h;
    check_eq($sformatf("i%0d_count", i), 32'(c), msize(i));
    check_eq($sformatf("i%0d_valid", i), 32'(v), 32'(msize(i) > 0));
    check_eq($sformatf("i%0d_rxen", i), 32'(en), 32'(m_run[i]));
    check_eq($sformatf("i%0d_ovf", i), 32'(o), 32'(m_ovf[i]));
    check_eq($sformatf("i%0d_errcnt", i), 32'(ec), m_err[i]);
    if (msize(i) > 0) begin
      h = mhead(i);
      check_eq($sformatf("i%0d_data", i), 32'(d), 32'(h[7:0]));
      check_eq($sformatf("i%0d_err", i), 32'(e), 32'(h[8]));
    end
  endtask

  task automatic compare_all();
    compare_inst(0, rx_en0, out_data0, out_err0, out_valid0, count0, ovf0, err_cnt0);
    compare_inst(1, rx_en1, out_data1, out_err1, out_valid1, count1, ovf1, err_cnt1);
  endtask

  // Inputs are stable here; model sees the same values the DUT samples at the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    rxBusy = 1'b0; rxDone = 1'b0; rxErr = 1'b0; outReady = 1'b0; ovfClr = 1'b0;
    #1;
    model_reset();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  task automatic push_byte(logic [7:0] b, logic e);
    rxByte = b; rxErr = e; rxDone = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();
    check_eq("reset_count", 32'(count0), 0);
    check_eq("reset_rxen", 32'(rx_en0), 1);

    // Single byte, pulse rxDone.
    rxByte = 8'hB5; rxDone = 1'b1;
    tick();
    check_eq("single_valid", 32'(out_valid0), 1);
    check_eq("single_data", 32'(out_data0), 32'hB5);
    check_eq("single_count", 32'(count0), 1);
    rxDone = 1'b0; outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check_eq("single_pop_count", 32'(count0), 0);
    check_eq("single_pop_valid", 32'(out_valid0), 0);

    // Held rxDone yields exactly one entry.
    rxByte = 8'h3C; rxDone = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    rxDone = 1'b0;
    tick();
    check_eq("held_count", 32'(count0), 1);
    outReady = 1'b1; tick(); outReady = 1'b0;

    // Error tagging on both instances.
    push_byte(8'hA5, 1'b1);
    check_eq("err_tag_err", 32'(out_err0), 1);
    check_eq("err_tag_data", 32'(out_data0), 32'hA5);
    check_eq("err_drop_count", 32'(count1), 0);
    check_eq("err_drop_errcnt", 32'(err_cnt1), 1);

    // Watermarks.
    do_reset();
    for (int i = 0; i < 12; i++) push_byte(8'(i + 8'h40), 1'b0);
    check_eq("hw_rxen_low", 32'(rx_en0), 0);
    outReady = 1'b1;
    while (msize(0) > LW) tick();
    outReady = 1'b0;
    tick();
    check_eq("lw_rxen_high", 32'(rx_en0), 1);

    // Busy frame defers the drop of rxEn.
    do_reset();
    for (int i = 0; i < 11; i++) push_byte(8'(i), 1'b0);
    rxBusy = 1'b1;
    push_byte(8'h77, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("busy_rxen_held", 32'(rx_en0), 1);
    rxBusy = 1'b0;
    tick();
    check_eq("busy_rxen_drop", 32'(rx_en0), 0);

    // Overflow.
    do_reset();
    for (int i = 0; i <= 16; i++) push_byte(8'(i), 1'b0);
    check_eq("ovf_count", 32'(count0), 16);
    check_eq("ovf_flag", 32'(ovf0), 1);
    check_eq("ovf_head", 32'(out_data0), 32'h00);
    rxByte = 8'h55; rxDone = 1'b1; outReady = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b0;
    tick();
    check_eq("full_pushpop_count", 32'(count0), 16);
    check_eq("full_pushpop_ovf", 32'(ovf0), 1);
    // Overflow event and clear in the same cycle: set wins.
    rxByte = 8'h66; rxDone = 1'b1; ovfClr = 1'b1;
    tick();
    rxDone = 1'b0; ovfClr = 1'b0;
    check_eq("ovf_set_wins", 32'(ovf0), 1);
    ovfClr = 1'b1; tick(); ovfClr = 1'b0;
    check_eq("ovf_clear", 32'(ovf0), 0);
    for (int i = 1; i <= 15; i++) begin
      check_eq("ovf_read_seq", 32'(out_data0), i);
      outReady = 1'b1; tick(); outReady = 1'b0;
    end
    check_eq("ovf_read_last", 32'(out_data0), 32'h55);

    // Async reset mid-cycle with count=5 and rxEn=0.
    do_reset();
    push_byte(8'hE1, 1'b1);
    for (int i = 0; i < 11; i++) push_byte(8'(i + 8'h10), 1'b0);
    outReady = 1'b1;
    while (msize(0) > 5) tick();
    outReady = 1'b0;
    tick();
    check_eq("pre_rst_count", 32'(count0), 5);
    check_eq("pre_rst_rxen", 32'(rx_en0), 0);
    #2;
    rstN = 1'b0;
    #1;
    check_eq("arst_count", 32'(count0), 0);
    check_eq("arst_valid", 32'(out_valid0), 0);
    check_eq("arst_rxen", 32'(rx_en0), 1);
    check_eq("arst_errcnt", 32'(err_cnt0), 0);
    model_reset();
    tick();
    rstN = 1'b1;
    tick();

    // errCount saturation.
    outReady = 1'b1;
    for (int i = 0; i < 260; i++) push_byte(8'($urandom), 1'b1);
    outReady = 1'b0;
    check_eq("errcnt_sat0", 32'(err_cnt0), 255);
    check_eq("errcnt_sat1", 32'(err_cnt1), 255);

    // Randomized traffic with alternating fill/drain phases.
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      bit fill_phase = ((c / 150) % 2) == 0;
      if (rxDone) rxDone = ($urandom_range(0, 3) == 0);
      else rxDone = ($urandom_range(0, 2) == 0);
      rxByte   = 8'($urandom);
      rxErr    = ($urandom_range(0, 7) == 0);
      rxBusy   = ($urandom_range(0, 3) == 0);
      outReady = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovfClr   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
